// File: rtl/servant_mem_sched.sv
// servant_mem_sched: round-robin share of the servant RAM port between ibus (0), dbus (1) and accelerator (2).
// Latency: request seen in IDLE -> o_mem_cyc next cycle, ack routed combinationally; one IDLE cycle between transactions.
// Backpressure: requesters hold cyc/req until ack/gnt; optional ack-timeout abort with SERVANT_MEM_SCHED_TIMEOUT_EN.
module servant_mem_sched #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  input  logic        i_acc_req,
  input  logic [31:0] i_acc_adr,
  input  logic [31:0] i_acc_wdata,
  input  logic [3:0]  i_acc_be,
  input  logic        i_acc_we,
  output logic        o_acc_gnt,
  output logic        o_acc_rvalid,
  output logic [31:0] o_acc_rdata,
  output logic [31:0] o_mem_adr,
  output logic [31:0] o_mem_dat,
  output logic [3:0]  o_mem_sel,
  output logic        o_mem_we,
  output logic        o_mem_cyc,
  input  logic [31:0] i_mem_rdt,
  input  logic        i_mem_ack,
  output logic        o_timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [1:0]  last_owner;
  logic [2:0]  req;
  logic [1:0]  c0, c1, win;
  logic        win_vld;
  logic        done;
  logic        abort;
  logic [31:0] rdt;

  assign req = {i_acc_req, i_dbus_cyc, i_ibus_cyc};

  // Priority order starts at the requester after the last owner; the last owner itself comes last.
  assign c0 = (last_owner == 2'd2) ? 2'd0 : last_owner + 2'd1;
  assign c1 = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;

  always_comb begin
    win_vld = |req;
    win     = last_owner;
    if (req[c0])      win = c0;
    else if (req[c1]) win = c1;
  end

  assign done = (state == BUSY) && (i_mem_ack || abort);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_acc_gnt = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = BUSY;
          o_acc_gnt = (win == 2'd2);
        end
      end
      BUSY: begin
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_owner <= 2'd2;
      o_mem_cyc  <= 1'b0;
      o_mem_adr  <= 32'h0;
      o_mem_dat  <= 32'h0;
      o_mem_sel  <= 4'h0;
      o_mem_we   <= 1'b0;
    end else if (state == IDLE && win_vld) begin
      last_owner <= win;
      o_mem_cyc  <= 1'b1;
      case (win)
        2'd0: begin
          o_mem_adr <= i_ibus_adr;
          o_mem_dat <= 32'h0;
          o_mem_sel <= 4'hF;
          o_mem_we  <= 1'b0;
        end
        2'd1: begin
          o_mem_adr <= i_dbus_adr;
          o_mem_dat <= i_dbus_dat;
          o_mem_sel <= i_dbus_sel;
          o_mem_we  <= i_dbus_we;
        end
        default: begin
          o_mem_adr <= i_acc_adr;
          o_mem_dat <= i_acc_wdata;
          o_mem_sel <= i_acc_be;
          o_mem_we  <= i_acc_we;
        end
      endcase
    end else if (done) begin
      o_mem_cyc <= 1'b0;
    end
  end

  // A real ack always beats an abort in the same cycle.
  assign rdt          = (abort && !i_mem_ack) ? 32'h0 : i_mem_rdt;
  assign o_ibus_rdt   = rdt;
  assign o_dbus_rdt   = rdt;
  assign o_acc_rdata  = rdt;
  assign o_ibus_ack   = done && (last_owner == 2'd0);
  assign o_dbus_ack   = done && (last_owner == 2'd1);
  assign o_acc_rvalid = done && (last_owner == 2'd2);

`ifdef SERVANT_MEM_SCHED_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_flag;

  assign abort     = (state == BUSY) && (tmo_cnt == 16'(TIMEOUT - 1));
  assign o_timeout = tmo_flag;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt  <= 16'h0;
      tmo_flag <= 1'b0;
    end else begin
      if (state == IDLE)   tmo_cnt <= 16'h0;
      else if (!i_mem_ack) tmo_cnt <= tmo_cnt + 16'h1;
      if (abort && !i_mem_ack) tmo_flag <= 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign abort     = 1'b0;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_servant_mem_sched.sv
// Directed bench for servant_mem_sched: reset, fetch, round-robin, acc write, reset mid-BUSY, timeout.
// Inputs driven 1ns after the rising edge; outputs sampled inside the same cycle.
module tb_servant_mem_sched;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic [31:0] i_dbus_adr, i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we, i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;
  logic        i_acc_req;
  logic [31:0] i_acc_adr, i_acc_wdata;
  logic [3:0]  i_acc_be;
  logic        i_acc_we;
  logic        o_acc_gnt, o_acc_rvalid;
  logic [31:0] o_acc_rdata;
  logic [31:0] o_mem_adr, o_mem_dat;
  logic [3:0]  o_mem_sel;
  logic        o_mem_we, o_mem_cyc;
  logic [31:0] i_mem_rdt;
  logic        i_mem_ack;
  logic        o_timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  servant_mem_sched #(.TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc), .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
    .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel), .i_dbus_we(i_dbus_we),
    .i_dbus_cyc(i_dbus_cyc), .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
    .i_acc_req(i_acc_req), .i_acc_adr(i_acc_adr), .i_acc_wdata(i_acc_wdata), .i_acc_be(i_acc_be),
    .i_acc_we(i_acc_we), .o_acc_gnt(o_acc_gnt), .o_acc_rvalid(o_acc_rvalid), .o_acc_rdata(o_acc_rdata),
    .o_mem_adr(o_mem_adr), .o_mem_dat(o_mem_dat), .o_mem_sel(o_mem_sel), .o_mem_we(o_mem_we),
    .o_mem_cyc(o_mem_cyc), .i_mem_rdt(i_mem_rdt), .i_mem_ack(i_mem_ack), .o_timeout(o_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_ibus_adr = 32'h0; i_ibus_cyc = 1'b0;
    i_dbus_adr = 32'h0; i_dbus_dat = 32'h0; i_dbus_sel = 4'h0; i_dbus_we = 1'b0; i_dbus_cyc = 1'b0;
    i_acc_req = 1'b0; i_acc_adr = 32'h0; i_acc_wdata = 32'h0; i_acc_be = 4'h0; i_acc_we = 1'b0;
    i_mem_rdt = 32'h0; i_mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  logic [31:0] rr_adr [3] = '{32'h1000, 32'h2000, 32'h3000};

  initial begin
    // reset state
    do_reset();
    #1;
    check("rst_cyc", 32'(o_mem_cyc), 0);
    check("rst_adr", o_mem_adr, 0);
    check("rst_dat", o_mem_dat, 0);
    check("rst_sel", 32'(o_mem_sel), 0);
    check("rst_we", 32'(o_mem_we), 0);
    check("rst_tmo", 32'(o_timeout), 0);
    check("rst_acks", 32'({o_acc_rvalid, o_dbus_ack, o_ibus_ack, o_acc_gnt}), 0);

    // single fetch
    i_ibus_cyc = 1'b1; i_ibus_adr = 32'h100;
    #1;
    check("t1_cyc_idle", 32'(o_mem_cyc), 0);
    tick();
    check("t1_cyc", 32'(o_mem_cyc), 1);
    check("t1_adr", o_mem_adr, 32'h100);
    check("t1_sel", 32'(o_mem_sel), 32'hF);
    check("t1_we", 32'(o_mem_we), 0);
    check("t1_dat", o_mem_dat, 0);
    check("t1_ack_early", 32'(o_ibus_ack), 0);
    tick();
    i_mem_ack = 1'b1; i_mem_rdt = 32'h13;
    #1;
    check("t1_ack", 32'(o_ibus_ack), 1);
    check("t1_rdt", o_ibus_rdt, 32'h13);
    check("t1_other_acks", 32'({o_acc_rvalid, o_dbus_ack}), 0);
    tick();
    i_mem_ack = 1'b0; i_ibus_cyc = 1'b0;
    #1;
    check("t1_cyc_done", 32'(o_mem_cyc), 0);
    check("t1_ack_done", 32'(o_ibus_ack), 0);

    // round-robin with all three requesting continuously
    do_reset();
    i_ibus_adr = rr_adr[0]; i_dbus_adr = rr_adr[1]; i_acc_adr = rr_adr[2];
    i_ibus_cyc = 1'b1; i_dbus_cyc = 1'b1; i_acc_req = 1'b1;
    for (int t = 0; t < 6; t++) begin
      int exp_owner;
      exp_owner = t % 3;
      #1;
      check("t2_gnt", 32'(o_acc_gnt), 32'(exp_owner == 2));
      tick();
      check("t2_adr", o_mem_adr, rr_adr[exp_owner]);
      check("t2_no_ack", 32'({o_acc_rvalid, o_dbus_ack, o_ibus_ack}), 0);
      tick();
      i_mem_ack = 1'b1; i_mem_rdt = 32'(t);
      #1;
      check("t2_ack", 32'({o_acc_rvalid, o_dbus_ack, o_ibus_ack}), 32'(3'b001 << exp_owner));
      tick();
      i_mem_ack = 1'b0;
    end
    i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0; i_acc_req = 1'b0;

    // accelerator write, inputs changed right after the grant
    i_acc_req = 1'b1; i_acc_adr = 32'h40; i_acc_wdata = 32'hCAFEF00D; i_acc_be = 4'h3; i_acc_we = 1'b1;
    #1;
    check("t3_gnt", 32'(o_acc_gnt), 1);
    tick();
    i_acc_req = 1'b0; i_acc_adr = 32'hFFFF; i_acc_wdata = 32'h0; i_acc_be = 4'hF; i_acc_we = 1'b0;
    #1;
    check("t3_adr", o_mem_adr, 32'h40);
    check("t3_dat", o_mem_dat, 32'hCAFEF00D);
    check("t3_sel", 32'(o_mem_sel), 32'h3);
    check("t3_we", 32'(o_mem_we), 1);
    check("t3_gnt_off", 32'(o_acc_gnt), 0);
    tick();
    i_mem_ack = 1'b1;
    #1;
    check("t3_adr_hold", o_mem_adr, 32'h40);
    check("t3_rvalid", 32'({o_acc_rvalid, o_dbus_ack, o_ibus_ack}), 32'b100);
    tick();
    i_mem_ack = 1'b0;
    #1;
    check("t3_rvalid_off", 32'(o_acc_rvalid), 0);
    check("t3_cyc_off", 32'(o_mem_cyc), 0);

    // reset mid-BUSY with ibus as owner; dbus pending
    i_ibus_cyc = 1'b1; i_ibus_adr = 32'h200;
    tick();
    check("t4_busy", 32'(o_mem_cyc), 1);
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h300;
    i_mem_ack = 1'b1; i_rst_n = 1'b0;
    #1;
    check("t4_cyc_rst", 32'(o_mem_cyc), 0);
    check("t4_no_ack", 32'({o_acc_rvalid, o_dbus_ack, o_ibus_ack}), 0);
    tick();
    i_rst_n = 1'b1; i_mem_ack = 1'b0;
    tick();
    check("t4_prio_ibus", o_mem_adr, 32'h200);
    tick();
    i_mem_ack = 1'b1;
    #1;
    check("t4_ibus_ack", 32'(o_ibus_ack), 1);
    tick();
    i_mem_ack = 1'b0; i_ibus_cyc = 1'b0;
    tick();
    check("t4_dbus_adr", o_mem_adr, 32'h300);
    tick();
    i_mem_ack = 1'b1;
    #1;
    check("t4_dbus_ack", 32'(o_dbus_ack), 1);
    tick();
    i_mem_ack = 1'b0; i_dbus_cyc = 1'b0;

`ifdef SERVANT_MEM_SCHED_TIMEOUT_EN
    // RAM never acks: abort in the 8th BUSY cycle
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h500; i_mem_rdt = 32'hDEADBEEF;
    tick();
    for (int b = 1; b < 8; b++) begin
      check("t5_wait", 32'(o_dbus_ack), 0);
      tick();
    end
    check("t5_abort_ack", 32'(o_dbus_ack), 1);
    check("t5_abort_rdt", o_dbus_rdt, 32'h0);
    check("t5_tmo_pre", 32'(o_timeout), 0);
    tick();
    i_dbus_cyc = 1'b0;
    check("t5_cyc_off", 32'(o_mem_cyc), 0);
    check("t5_tmo_set", 32'(o_timeout), 1);
    i_ibus_cyc = 1'b1; i_ibus_adr = 32'h600;
    tick();
    check("t5_next_adr", o_mem_adr, 32'h600);
    tick();
    i_mem_ack = 1'b1; i_mem_rdt = 32'h77;
    #1;
    check("t5_next_ack", 32'(o_ibus_ack), 1);
    check("t5_next_rdt", o_ibus_rdt, 32'h77);
    check("t5_tmo_sticky", 32'(o_timeout), 1);
    tick();
    i_mem_ack = 1'b0; i_ibus_cyc = 1'b0;

    // ack coincides with the timeout cycle: ack wins
    do_reset();
    #1;
    check("t6_tmo_rst", 32'(o_timeout), 0);
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h700;
    tick();
    for (int b = 1; b < 8; b++) tick();
    i_mem_ack = 1'b1; i_mem_rdt = 32'h12345678;
    #1;
    check("t6_ack", 32'(o_dbus_ack), 1);
    check("t6_rdt", o_dbus_rdt, 32'h12345678);
    tick();
    i_mem_ack = 1'b0; i_dbus_cyc = 1'b0;
    check("t6_tmo", 32'(o_timeout), 0);
    check("t6_cyc_off", 32'(o_mem_cyc), 0);
`else
    // without the timeout feature BUSY waits indefinitely
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h500;
    tick();
    for (int b = 0; b < 20; b++) begin
      check("t5_hold_cyc", 32'(o_mem_cyc), 1);
      check("t5_hold_ack", 32'(o_dbus_ack), 0);
      tick();
    end
    i_mem_ack = 1'b1; i_mem_rdt = 32'h12345678;
    #1;
    check("t5_late_ack", 32'(o_dbus_ack), 1);
    check("t5_late_rdt", o_dbus_rdt, 32'h12345678);
    tick();
    i_mem_ack = 1'b0; i_dbus_cyc = 1'b0;
    check("t5_tmo", 32'(o_timeout), 0);
    check("t5_cyc_off", 32'(o_mem_cyc), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
